// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard sequencer
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MC_LATENCY_MIN = 2;

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// rtl/hazard_sequencer_load_use_detect.sv - combinational load-use hazard compare between EX load and ID sources
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_write_reg,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_write_reg == id_rs);
    assign rt_match = id_uses_rt & (ex_write_reg == id_rt);

    // r0 is hardwired zero, so a load targeting it can never feed a consumer
    assign hazard = ex_mem_read & ex_reg_write & (ex_write_reg != REG_ZERO)
                  & (rs_match | rt_match);

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - PC/pipeline-register control for load-use, branch flush and multi-cycle EX
// Optional HAZARD_PERF_EN adds stall_cycles/flush_count performance counters.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_mc_start,
    input  logic        mem_branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        mc_busy
);

    localparam int             MC_LAT_EFF  = (MC_LATENCY < MC_LATENCY_MIN) ? MC_LATENCY_MIN : MC_LATENCY;
    localparam logic [CNT_W-1:0] MC_CNT_INIT = CNT_W'(MC_LAT_EFF - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             branch_flush;

    load_use_detect u_load_use_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_write_reg (ex_write_reg),
        .hazard       (hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!mem_branch_taken && ex_mc_start) begin
                    state_d = MC_WAIT;
                    cnt_d   = MC_CNT_INIT;
                end
            end
            MC_WAIT: begin
                // A taken branch here abandons the wrong-path op in EX
                if (mem_branch_taken) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mc_busy       = 1'b0;
        branch_flush  = 1'b0;
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (mem_branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            branch_flush  = 1'b1;
        end else if ((state_q == RUN && ex_mc_start) || (state_q == MC_WAIT && cnt_q != '0)) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mc_busy       = 1'b1;
        end else begin
            // Plain RUN or the release cycle, where EX/MEM takes the result
            mc_busy = (state_q == MC_WAIT);
            if (hazard) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (branch_flush) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_write_reg;
    logic       id_uses_rt, ex_mem_read, ex_reg_write, ex_mc_start, mem_branch_taken;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mc_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mc_busy}
    localparam logic [6:0] O_RESET     = 7'b0011110;
    localparam logic [6:0] O_IDLE      = 7'b1101000;
    localparam logic [6:0] O_STALL     = 7'b0001100;
    localparam logic [6:0] O_HOLD      = 7'b0000011;
    localparam logic [6:0] O_REL       = 7'b1101001;
    localparam logic [6:0] O_REL_STALL = 7'b0001101;
    localparam logic [6:0] O_BRANCH    = 7'b1111110;

    logic [6:0] outs;
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mc_busy};

    always #5 clk = ~clk;

    hazard_sequencer #(.MC_LATENCY(4), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_reg_write     (ex_reg_write),
        .ex_write_reg     (ex_write_reg),
        .ex_mc_start      (ex_mc_start),
        .mem_branch_taken (mem_branch_taken),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_write      (id_ex_write),
        .id_ex_bubble     (id_ex_bubble),
        .ex_mem_bubble    (ex_mem_bubble),
`ifdef HAZARD_PERF_EN
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count),
`endif
        .mc_busy          (mc_busy)
    );

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mr, input logic rw, input logic [4:0] wr,
                         input logic mc, input logic br);
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_reg_write = rw; ex_write_reg = wr;
        ex_mc_start = mc; mem_branch_taken = br;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Check the combinational outputs mid-cycle, then advance to just after the next edge
    task automatic cyc(input string tag, input logic [6:0] exp);
        #2;
        tests_run++;
        assert (outs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, outs, exp);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
`endif

    initial begin
        // 1. Reset with random inputs
        rst = 1'b1;
        drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom));
        cyc("reset_c0", O_RESET);
        drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom));
        cyc("reset_c1", O_RESET);
        rst = 1'b0;
        idle();
        cyc("after_reset_idle", O_IDLE);

        // 2. Load-use
        drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        cyc("lu_rs_match", O_STALL);
        idle();
        cyc("lu_one_cycle_only", O_IDLE);
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        cyc("lu_reg_zero", O_IDLE);
        drive(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        cyc("lu_rt_unused", O_IDLE);
        drive(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        cyc("lu_rt_used", O_STALL);
        drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
        cyc("lu_no_regwrite", O_IDLE);
        drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        cyc("lu_not_load", O_IDLE);

        // 3. Multi-cycle, start held high throughout
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("mc_hold1", O_HOLD);
        cyc("mc_hold2", O_HOLD);
        cyc("mc_hold3", O_HOLD);
        cyc("mc_release", O_REL);
        idle();
        cyc("mc_after", O_IDLE);

        // 4. Branch beats multi-cycle start and load-use
        drive(5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
        cyc("br_priority", O_BRANCH);
        idle();
        cyc("br_no_hold_next", O_IDLE);

        // 5. Load-use on the release cycle
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("rel_hold1", O_HOLD);
        idle();
        cyc("rel_hold2", O_HOLD);
        cyc("rel_hold3", O_HOLD);
        drive(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        cyc("rel_loaduse", O_REL_STALL);
        idle();
        cyc("rel_back_run", O_IDLE);

        // Branch in MC_WAIT aborts the op
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("abort_start", O_HOLD);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("abort_branch", O_BRANCH);
        idle();
        cyc("abort_run", O_IDLE);

        // Reset mid-MC_WAIT
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("rstmc_start", O_HOLD);
        rst = 1'b1;
        idle();
        cyc("rstmc_reset", O_RESET);
        rst = 1'b0;
        cyc("rstmc_run", O_IDLE);

`ifdef HAZARD_PERF_EN
        // 6. Counters: one MC op then one branch
        rst = 1'b1;
        cyc("perf_reset", O_RESET);
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("perf_hold1", O_HOLD);
        cyc("perf_hold2", O_HOLD);
        cyc("perf_hold3", O_HOLD);
        idle();
        cyc("perf_release", O_REL);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("perf_branch", O_BRANCH);
        idle();
        chk32("perf_stall_cycles", stall_cycles, 32'd3);
        chk32("perf_flush_count", flush_count, 32'd1);
        rst = 1'b1;
        cyc("perf_rst2", O_RESET);
        chk32("perf_stall_clear", stall_cycles, 32'd0);
        chk32("perf_flush_clear", flush_count, 32'd0);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control sequencer for the 5-stage IF/ID/EX/MEM/WB datapath.
- Drives the PC write enable and the write-enable, flush and bubble controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles three events: load-use stalls, taken-branch flushes resolved in MEM, and multi-cycle EX operations such as SAD accumulate/multiply that hold EX for MC_LATENCY cycles.
- Sits beside the top level; its outputs gate the existing PC and pipeline registers.

Parameters:
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX; legal range 2..16.
- CNT_W, 4, width of the multi-cycle down-counter; must satisfy 2^CNT_W >= MC_LATENCY-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_write_reg  in  5  destination register of the EX instruction (post RegDst mux).
- ex_mc_start  in  1  EX instruction is a multi-cycle op.
- mem_branch_taken  in  1  branch in MEM is taken (Branch AND Zero).
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  load zero controls into ID/EX.
- ex_mem_bubble  out  1  load zero controls into EX/MEM.
- mc_busy  out  1  multi-cycle op in progress.

Behaviour:
- State register: RUN or MC_WAIT, plus down-counter cnt[CNT_W-1:0]. All outputs are combinational from state, cnt and inputs.
- Reset, while rst=1:
  - Outputs forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_write=1, id_ex_bubble=1, ex_mem_bubble=1, mc_busy=0.
  - Next state RUN, cnt=0.
  - Reset mid-MC_WAIT aborts the op.
- Default in RUN with no event: pc_write=1, if_id_write=1, id_ex_write=1, all flush/bubble outputs 0, mc_busy=0.
- Priority in RUN: branch > multi-cycle start > load-use.
- Branch (mem_branch_taken=1):
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1 for that cycle.
  - ex_mc_start and load-use are ignored that cycle; the EX instruction is on the wrong path. Stay in RUN.
- Multi-cycle start (ex_mc_start=1, no branch):
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, mc_busy=1.
  - cnt<=MC_LATENCY-2; next state MC_WAIT.
- MC_WAIT, cnt!=0: same hold outputs as the start cycle, mc_busy=1, cnt<=cnt-1.
- MC_WAIT, cnt==0 (release cycle):
  - Default RUN outputs, mc_busy=1; EX/MEM captures the result; next state RUN.
  - Load-use is evaluated normally in this cycle.
- Multi-cycle totals: hold asserted for exactly MC_LATENCY-1 cycles; op occupies EX for MC_LATENCY cycles. ex_mc_start is ignored throughout MC_WAIT.
- Load-use (RUN or release cycle):
  - Condition: hazard = ex_mem_read & ex_reg_write & (ex_write_reg!=0) & ((ex_write_reg==id_rs) | (id_uses_rt & ex_write_reg==id_rt)).
  - Response: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1 for one cycle; no state change.
  - Register 0 never stalls.
- Branch during MC_WAIT (illegal, but defined): treated as the branch case; cnt<=0, next state RUN, mc_busy=0 that cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments every cycle with pc_write=0 and rst=0.
  - flush_count increments on each branch flush.
  - Both clear on rst and wrap modulo 2^32.
- When undefined, the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package hazard_pkg: state enum (RUN=1'b0, MC_WAIT=1'b1), REG_ZERO=5'd0, MC_LATENCY_MIN=2.
- One natural sub-module: load_use_detect, the combinational hazard compare. The FSM and counter stay in hazard_sequencer.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> if_id_flush=id_ex_bubble=ex_mem_bubble=1, pc_write=0. After release with idle inputs -> pc_write=if_id_write=id_ex_write=1.
2. Load-use: ex_mem_read=1, ex_reg_write=1, ex_write_reg=5, id_rs=5 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_write_reg=0 -> no stall. Repeat with id_rt=5, id_uses_rt=0 -> no stall.
3. Multi-cycle, MC_LATENCY=4: ex_mc_start held high -> hold outputs for exactly 3 cycles, mc_busy high for 4 cycles, pc_write returns to 1 in the 4th cycle.
4. Simultaneous events: mem_branch_taken=1 with ex_mc_start=1 and a load-use match -> flush outputs asserted, pc_write=1, state remains RUN, no hold next cycle.
5. Release plus load-use: load-use condition presented on the MC_WAIT cnt==0 cycle -> stall asserted that cycle, state RUN next.
6. With HAZARD_PERF_EN: scenario 3 followed by one branch -> stall_cycles=3, flush_count=1. Assert rst -> both read 0.
